// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: width_sel encodings, per-size data/parity counts and
// the data-bit to Hamming-position table used by both encoder and decoder.
package ecc_pkg;

    typedef enum logic [1:0] {
        ECC_SMALL   = 2'b00,
        ECC_MEDIUM  = 2'b01,
        ECC_LARGE   = 2'b10,
        ECC_ILLEGAL = 2'b11
    } ecc_width_e;

    localparam int ECC_DATA_SMALL  = 4;
    localparam int ECC_DATA_MEDIUM = 11;
    localparam int ECC_DATA_LARGE  = 26;

    // Parity counts include the overall parity bit.
    localparam int ECC_PAR_SMALL  = 4;
    localparam int ECC_PAR_MEDIUM = 5;
    localparam int ECC_PAR_LARGE  = 6;

    // p(j): the (j+1)-th non-power-of-two position >= 3.
    localparam logic [4:0] ECC_POS [0:ECC_DATA_LARGE-1] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13,
        5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
        5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31
    };

    function automatic int ecc_data_bits(input logic [1:0] sel);
        case (sel)
            ECC_SMALL:  return ECC_DATA_SMALL;
            ECC_MEDIUM: return ECC_DATA_MEDIUM;
            ECC_LARGE:  return ECC_DATA_LARGE;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/ecc_parity_gen.sv
// Combinational SECDED parity generator: Hamming parity, overall parity and the
// assembled codeword {0, P_top, P_k-1..P_0, data} for the selected size.
module ecc_parity_gen
    import ecc_pkg::*;
(
    input  logic [ECC_DATA_LARGE-1:0] data,
    input  logic [1:0]                width_sel,
    output logic [5:0]                parity,
    output logic [31:0]               codeword
);

    logic [ECC_DATA_LARGE-1:0] data_m;
    logic [4:0]                ham;
    logic                      p_top;
    int                        n_bits;

    // Hamming parity vector is the XOR of the positions of all set data bits;
    // positions never exceed the size's parity width, so upper bits stay zero.
    always_comb begin
        n_bits = ecc_data_bits(width_sel);
        data_m = '0;
        ham    = '0;
        for (int j = 0; j < ECC_DATA_LARGE; j++) begin
            if (j < n_bits && data[j]) begin
                data_m[j] = 1'b1;
                ham       = ham ^ ECC_POS[j];
            end
        end
        p_top  = (^data_m) ^ (^ham);
        parity = {p_top, ham};
        case (width_sel)
            ECC_SMALL:  codeword = {24'b0, p_top, ham[2:0], data_m[3:0]};
            ECC_MEDIUM: codeword = {16'b0, p_top, ham[3:0], data_m[10:0]};
            ECC_LARGE:  codeword = {p_top, ham, data_m};
            default:    codeword = '0;
        endcase
    end

endmodule

// File: rtl/ecc_encoder_pipe.sv
// Two-stage pipelined SECDED encoder with valid/ready flow control on both sides.
// Optional ECC_ENC_ERR_INJECT_EN adds inject_en/inject_mask for deliberate error injection.
module ecc_encoder_pipe
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int AMBA_WORD  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            width_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AMBA_WORD-1:0]  codeword_out,
    output logic                  out_err,
    output logic [CNT_WIDTH-1:0]  word_cnt
`ifdef ECC_ENC_ERR_INJECT_EN
    ,
    input  logic                  inject_en,
    input  logic [AMBA_WORD-1:0]  inject_mask
`endif
);

    logic                      s1_valid_q, s1_valid_d;
    logic [ECC_DATA_LARGE-1:0] s1_data_q, s1_data_d;
    logic [1:0]                s1_sel_q, s1_sel_d;
    logic                      out_valid_q, out_valid_d;
    logic [AMBA_WORD-1:0]      codeword_q, codeword_d;
    logic                      out_err_q, out_err_d;
    logic [CNT_WIDTH-1:0]      word_cnt_q, word_cnt_d;
    logic                      s2_load, in_fire;
    logic [31:0]               gen_cw;
    logic [AMBA_WORD-1:0]      cw_final;
    logic [5:0]                gen_parity_unused;
    logic                      unused_hi;

    assign unused_hi = ^data_in[DATA_WIDTH-1:ECC_DATA_LARGE];

    ecc_parity_gen u_parity_gen (
        .data      (s1_data_q),
        .width_sel (s1_sel_q),
        .parity    (gen_parity_unused),
        .codeword  (gen_cw)
    );

`ifdef ECC_ENC_ERR_INJECT_EN
    logic                 s1_inj_en_q, s1_inj_en_d;
    logic [AMBA_WORD-1:0] s1_inj_mask_q, s1_inj_mask_d;
    logic [AMBA_WORD-1:0] size_mask;

    always_comb begin
        s1_inj_en_d   = s1_inj_en_q;
        s1_inj_mask_d = s1_inj_mask_q;
        if (in_fire) begin
            s1_inj_en_d   = inject_en;
            s1_inj_mask_d = inject_mask;
        end
        case (s1_sel_q)
            ECC_SMALL:  size_mask = 32'h0000_00FF;
            ECC_MEDIUM: size_mask = 32'h0000_FFFF;
            ECC_LARGE:  size_mask = 32'hFFFF_FFFF;
            default:    size_mask = '0;
        endcase
        cw_final = gen_cw ^ (s1_inj_en_q ? (s1_inj_mask_q & size_mask) : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_inj_en_q   <= 1'b0;
            s1_inj_mask_q <= '0;
        end else begin
            s1_inj_en_q   <= s1_inj_en_d;
            s1_inj_mask_q <= s1_inj_mask_d;
        end
    end
`else
    assign cw_final = gen_cw;
`endif

    always_comb begin
        s2_load  = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_load;
        in_fire  = in_valid && in_ready;

        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_sel_d    = s1_sel_q;
        out_valid_d = out_valid_q;
        codeword_d  = codeword_q;
        out_err_d   = out_err_q;
        word_cnt_d  = word_cnt_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_data_d = data_in[ECC_DATA_LARGE-1:0];
            s1_sel_d  = width_sel;
        end
        // Output data only changes on a real load so stalled values stay put.
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                codeword_d = cw_final;
                out_err_d  = (s1_sel_q == ECC_ILLEGAL);
            end
        end
        if (out_valid_q && out_ready) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_sel_q    <= '0;
            out_valid_q <= 1'b0;
            codeword_q  <= '0;
            out_err_q   <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sel_q    <= s1_sel_d;
            out_valid_q <= out_valid_d;
            codeword_q  <= codeword_d;
            out_err_q   <= out_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign codeword_out = codeword_q;
    assign out_err      = out_err_q;
    assign word_cnt     = word_cnt_q;

endmodule
